// File: rtl/alu_issue.sv
// alu_issue: single-issue ALU sequencer with register file, driving an external combinational ALU
module alu_issue #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_imm,
  input  logic        req_use_imm,
  input  logic        req_is_branch,
  input  logic        req_invert,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [3:0]  alu_control,
  output logic        alu_invert_cond,
  input  logic [31:0] alu_result,
  input  logic        alu_take_branch,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_take_branch,
  output logic [4:0]  rsp_rd,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] retired
);
  localparam logic [3:0] ALU_NOOP = 4'd0;
  localparam int AW = NREGS > 1 ? $clog2(NREGS) : 1;
  localparam logic [5:0] NR = 6'(NREGS);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] regs_q [NREGS];
  logic [3:0]  op_q;
  logic [4:0]  rd_q, rsp_rd_q;
  logic        br_q, inv_q, tb_q;
  logic [31:0] a_q, b_q, res_q, retired_q;
  // Index 0 and indices beyond the file alias the hardwired zero register
  function automatic logic live(input logic [4:0] a);
    return a != 5'd0 && {1'b0, a} < NR;
  endfunction
  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    return live(a) ? regs_q[a[AW-1:0]] : 32'd0;
  endfunction
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && req_valid) ? EXEC :
              (state_q == EXEC) ? RESP :
              (state_q == RESP && rsp_ready) ? IDLE : state_q;
    req_ready       = state_q == IDLE && !rst;
    rsp_valid       = state_q == RESP && !rst;
    alu_control     = state_q == EXEC ? op_q : ALU_NOOP;
    alu_src_a       = state_q == EXEC ? a_q : 32'd0;
    alu_src_b       = state_q == EXEC ? b_q : 32'd0;
    alu_invert_cond = state_q == EXEC && inv_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
      res_q     <= 32'd0;
      tb_q      <= 1'b0;
      rsp_rd_q  <= 5'd0;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        op_q  <= req_op;
        rd_q  <= req_rd;
        br_q  <= req_is_branch;
        inv_q <= req_invert;
        a_q   <= rd_reg(req_rs1);
        b_q   <= req_use_imm ? req_imm : rd_reg(req_rs2);
      end
      if (state_q == EXEC) begin
        res_q    <= alu_result;
        tb_q     <= br_q && alu_take_branch;
        rsp_rd_q <= rd_q;
        if (!br_q && live(rd_q)) regs_q[rd_q[AW-1:0]] <= alu_result;
      end
      if (state_q == RESP && rsp_ready) retired_q <= retired_q + 32'd1;
    end
  end
  assign rsp_result      = res_q;
  assign rsp_take_branch = tb_q;
  assign rsp_rd          = rsp_rd_q;
  assign retired         = retired_q;
  assign dbg_data        = rd_reg(dbg_addr);
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of 32-bit architectural registers (power of 2, ≤32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1 and req_ready output 1; valid/ready request handshake.
REQ-005 SHALL have port req_op  input  alu_control_t (4)  ALU operation.
REQ-006 SHALL have ports req_rs1, req_rs2, req_rd  input  5 each  register indices.
REQ-007 SHALL have ports req_imm input 32 and req_use_imm input 1; when set, src_b is req_imm.
REQ-008 SHALL have ports req_is_branch input 1 and req_invert input 1; branch request, condition inversion.
REQ-009 SHALL have ports alu_src_a output 32, alu_src_b output 32, alu_control output alu_control_t, alu_invert_cond output 1; drive external ALU.
REQ-010 SHALL have ports alu_result input 32 and alu_take_branch input 1; combinational ALU response.
REQ-011 SHALL have ports rsp_valid output 1 and rsp_ready input 1; response handshake.
REQ-012 SHALL have ports rsp_result output 32, rsp_take_branch output 1, rsp_rd output 5; response payload.
REQ-013 SHALL have ports dbg_addr input 5 and dbg_data output 32; combinational register read.
REQ-014 SHALL have port retired output 32; count of completed responses.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 SHALL, on req_valid&&req_ready, latch op, rd, is_branch, invert, src_a=reg[rs1], src_b=use_imm?imm:reg[rs2], and go EXEC.
REQ-018 SHALL read register 0 as 0 always; writes to rd=0 discarded.
REQ-019 SHALL drive alu_* from latched values in EXEC only; outside EXEC alu_control=ALU_NOOP, alu_src_a/b=0, alu_invert_cond=0.
REQ-020 SHALL, at end of the single EXEC cycle, capture alu_result into rsp_result and alu_take_branch into rsp_take_branch, and go RESP.
REQ-021 SHALL, in that same edge, write alu_result to reg[rd] iff !is_branch and rd≠0.
REQ-022 SHALL hold rsp_take_branch=0 for non-branch requests.
REQ-023 SHALL assert rsp_valid only in RESP; payload stable while rsp_valid&&!rsp_ready.
REQ-024 SHALL, on rsp_valid&&rsp_ready, increment retired (wraps 0xFFFFFFFF→0) and go IDLE.
REQ-025 SHALL give latency of 2 cycles accept→rsp_valid; max throughput one request per 3 cycles.
REQ-026 SHALL make the register write visible to a request accepted in the cycle after the response handshake (no forwarding needed).
REQ-027 SHALL return reg[dbg_addr] combinationally, reflecting writes from the next cycle on; dbg_addr≥NREGS returns 0.
REQ-028 SHALL treat rs/rd indices ≥NREGS as register 0.

Reset
REQ-029 SHALL, when rst sampled high, enter IDLE, clear all registers, rsp_result, rsp_take_branch, rsp_rd, retired to 0, in any state.
REQ-030 SHALL drive rsp_valid=0, req_ready=0 during the reset cycle and req_ready=1 the cycle after.
REQ-031 SHALL abandon an in-flight request on reset mid-EXEC/RESP with no register write.

Verification
REQ-032 Immediate add: op=ALU_ADD, rs1=0, imm=5, use_imm, rd=3 -> rsp_result=5 two cycles after accept, dbg_addr=3 reads 5.
REQ-033 Register chain: reg3=5, reg4=7 set; op=ALU_SUB rs1=4 rs2=3 rd=5 -> rsp_result=2, reg5=2.
REQ-034 Branch: reg1=9, reg2=9, op=ALU_EQUAL, is_branch, invert=0 -> rsp_take_branch=1, no register write; invert=1 -> 0.
REQ-035 Backpressure: rsp_ready low 4 cycles -> rsp_valid held, payload stable, req_ready=0, retired increments once.
REQ-036 Write to x0: rd=0, imm=0xDEADBEEF -> rsp_result=0xDEADBEEF, dbg_addr=0 reads 0.
REQ-037 Reset in RESP: rst pulse -> rsp_valid=0 next cycle, all registers and retired read 0.
